bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/bus_arbiter_rr_pick.sv | 40 ++++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared FSM encoding and default sizing for the bus arbiter.
// The optional ownership timeout is enabled by the BUS_ARB_TIMEOUT_EN macro.
package bus_arb_pkg;

    localparam int unsigned NREQ_DEFAULT        = 4;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: the first eligible requester at or after
// rr_ptr, searching upward and wrapping from NREQ-1 to 0.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [SELW-1:0] rr_ptr,
    output logic            valid,
    output logic [SELW-1:0] index
);

    localparam logic [SELW:0] NREQ_W = (SELW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SELW:0]     sum;

    // Rotate so bit 0 of rot is the requester at rr_ptr.
    assign dbl = {eligible, eligible};
    assign rot = NREQ'(dbl >> rr_ptr);

    always_comb begin
        valid = 1'b0;
        index = '0;
        sum   = '0;
        // Walk downward so the smallest offset from rr_ptr is written last.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, rr_ptr} + (SELW+1)'(i);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                valid = 1'b1;
                index = sum[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter (IDLE/OWN/GAP) with a one-cycle turnaround between owners.
// Define BUS_ARB_TIMEOUT_EN to bound ownership to TIMEOUT_CYC cycles and add timeout_err.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ        = NREQ_DEFAULT,
    parameter int unsigned SELW        = 2,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stop,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] bus_sel,
`ifdef BUS_ARB_TIMEOUT_EN
    output logic            bus_busy,
    output logic            timeout_err
`else
    output logic            bus_busy
`endif
);

    if (SELW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("bus_arbiter: illegal NREQ/SELW/TIMEOUT_CYC combination");
    end

    state_e          state_q, state_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0] ptr_after_owner;
    logic [SELW-1:0] pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] eligible;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT_CYC) + 1;

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic            err_q, err_d;
    logic            expired;

    assign expired     = (state_q == OWN) && (cnt_q == CNTW'(TIMEOUT_CYC - 1));
    assign eligible    = req & ~mask_q;
    assign timeout_err = err_q;
`else
    assign eligible    = req;
`endif

    assign ptr_after_owner = (owner_q == SELW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    rr_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .valid    (pick_valid),
        .index    (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d    = '0;
        // A mask bit stays set only while its requester keeps req high.
        mask_d   = mask_q & req;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE, GAP: begin
                if (!stop && pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
`ifdef BUS_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (!req[owner_q]) begin
                    state_d  = GAP;
                    rr_ptr_d = ptr_after_owner;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (expired) begin
                    state_d          = GAP;
                    rr_ptr_d         = ptr_after_owner;
                    err_d            = 1'b1;
                    mask_d[owner_q]  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        bus_sel  = '0;
        bus_busy = 1'b0;
        if (state_q == OWN) begin
            grant[owner_q] = 1'b1;
            bus_sel        = owner_q;
            bus_busy       = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; the timeout scenario runs only when
// BUS_ARB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYC=8).
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       stop;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] bus_sel;
    logic       bus_busy;
`ifdef BUS_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .NREQ        (4),
        .SELW        (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stop        (stop),
        .req         (req),
        .grant       (grant),
        .bus_sel     (bus_sel),
`ifdef BUS_ARB_TIMEOUT_EN
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
`else
        .bus_busy    (bus_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        stop = 1'b0;
        req  = 4'b0000;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || bus_sel !== 2'd0 || bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%b sel=%0d busy=%b want 0000/0/0",
                     grant, bus_sel, bus_busy);
        end
`ifdef BUS_ARB_TIMEOUT_EN
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
        end
`endif
        #9 rst = 1'b0;
        req = 4'b0100;
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL grant_before_edge: got %b want 0000", grant);
        end
    endtask

    task automatic test_basic_grant;
        tick();
        checks++;
        if (grant !== 4'b0100 || bus_sel !== 2'd2 || bus_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_grant: grant=%b sel=%0d busy=%b want 0100/2/1",
                     grant, bus_sel, bus_busy);
        end
    endtask

    task automatic test_handoff;
        @(negedge clk) req = 4'b1101;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL handoff_hold: got %b want 0100", grant);
        end
        @(negedge clk) req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b0000 || bus_busy !== 1'b0 || bus_sel !== 2'd0) begin
            failures++;
            $display("FAIL handoff_gap: grant=%b busy=%b sel=%0d want 0000/0/0",
                     grant, bus_busy, bus_sel);
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || bus_sel !== 2'd3) begin
            failures++;
            $display("FAIL handoff_next: grant=%b sel=%0d want 1000/3", grant, bus_sel);
        end
        @(negedge clk) req = 4'b0000;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL handoff_release: got %b want 0000", grant);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            @(negedge clk) req = 4'b1111;
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (grant !== exp_g || bus_sel !== 2'(k % 4)) begin
                    failures++;
                    $display("FAIL rr_own k=%0d c=%0d: grant=%b sel=%0d want %b/%0d",
                             k, c, grant, bus_sel, exp_g, k % 4);
                end
            end
            @(negedge clk) req = 4'b1111 & ~exp_g;
            tick();
            checks++;
            if (grant !== 4'b0000) begin
                failures++;
                $display("FAIL rr_gap k=%0d: got %b want 0000", k, grant);
            end
        end
        @(negedge clk) req = 4'b0000;
        tick();
    endtask

    // rr_ptr is 1 on entry (owner 0 was the last to release).
    task automatic test_stop;
        @(negedge clk) begin
            stop = 1'b1;
            req  = 4'b0010;
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0000) begin
                failures++;
                $display("FAIL stop_idle c=%0d: got %b want 0000", c, grant);
            end
        end
        @(negedge clk) stop = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0010 || bus_sel !== 2'd1) begin
            failures++;
            $display("FAIL stop_release: grant=%b sel=%0d want 0010/1", grant, bus_sel);
        end
        @(negedge clk) begin
            stop = 1'b1;
            req  = 4'b1011;
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0010 || bus_sel !== 2'd1) begin
                failures++;
                $display("FAIL stop_no_preempt c=%0d: grant=%b sel=%0d want 0010/1",
                         c, grant, bus_sel);
            end
        end
        @(negedge clk) req = 4'b1001;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL stop_after_gap: got %b want 0000", grant);
        end
        @(negedge clk) stop = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b1000) begin
            failures++;
            $display("FAIL stop_ptr_wrap: got %b want 1000", grant);
        end
        @(negedge clk) req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        @(negedge clk) req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL rst_mid_pre: got %b want 0001", grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || bus_busy !== 1'b0 || bus_sel !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_async: grant=%b busy=%b sel=%0d want 0000/0/0",
                     grant, bus_busy, bus_sel);
        end
        @(negedge clk) begin
            rst = 1'b0;
            req = 4'b1000;
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || bus_sel !== 2'd3) begin
            failures++;
            $display("FAIL rst_mid_after: grant=%b sel=%0d want 1000/3", grant, bus_sel);
        end
        @(negedge clk) req = 4'b0000;
        tick();
        tick();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout;
        @(negedge clk) req = 4'b1001;
        tick();
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL to_own c=%0d: grant=%b err=%b want 0001/0",
                         c, grant, timeout_err);
            end
            if (c < 7) tick();
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_revoke: grant=%b err=%b want 0000/1", grant, timeout_err);
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_next_owner: grant=%b err=%b want 1000/0", grant, timeout_err);
        end
        tick();
        @(negedge clk) req = 4'b0001;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL to_masked c=%0d: grant=%b err=%b want 0000/0",
                         c, grant, timeout_err);
            end
            tick();
        end
        @(negedge clk) req = 4'b0000;
        tick();
        @(negedge clk) req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL to_unmask: got %b want 0001", grant);
        end
        @(negedge clk) req = 4'b0000;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_grant();
        test_handoff();
        test_round_robin();
        test_stop();
        test_reset_mid();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
